elevator_scan_controller: RTL and testbench

ELEVATOR_SCAN_CONTROLLER -- requirements
Module: elevator_scan_controller

---
 rtl/elevator_scan_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_controller.sv
// Elevator SCAN controller: latches floor calls, moves the car one floor per
// MOVE_TICKS timing ticks, keeps travelling in the current direction while
// calls remain ahead, and opens the door for DOOR_TICKS ticks at served floors.
module elevator_scan_controller #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2,
    parameter int TICK_DIV   = 100000000,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  door_open,
    output logic                  tick
);

    localparam int PRESC_W = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int MOVE_W  = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int DOOR_W  = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    // One-hot decode of a floor index.
    function automatic logic [NUM_FLOORS-1:0] f_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] v;
        v = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            v[i] = (32'(i) == 32'(f));
        end
        return v;
    endfunction

    // Mask of all floors strictly above f.
    function automatic logic [NUM_FLOORS-1:0] f_above(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] v;
        v = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            v[i] = (32'(i) > 32'(f));
        end
        return v;
    endfunction

    // Mask of all floors strictly below f.
    function automatic logic [NUM_FLOORS-1:0] f_below(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] v;
        v = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            v[i] = (32'(i) < 32'(f));
        end
        return v;
    endfunction

    state_t                r_state;
    logic [FLOOR_W-1:0]    r_cur_floor;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_last_up;
    logic [PRESC_W-1:0]    r_presc;
    logic [MOVE_W-1:0]     r_move_cnt;
    logic [DOOR_W-1:0]     r_door_cnt;

    state_t                w_state_nxt;
    logic [FLOOR_W-1:0]    w_floor_nxt;
    logic                  w_last_up_nxt;
    logic [MOVE_W-1:0]     w_move_cnt_nxt;
    logic [DOOR_W-1:0]     w_door_cnt_nxt;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_pend_req;

    logic                  w_tick;
    logic                  w_top;
    logic                  w_bottom;
    logic [FLOOR_W-1:0]    w_up_floor;
    logic [FLOOR_W-1:0]    w_dn_floor;
    logic                  w_idle_here;
    logic                  w_idle_above;
    logic                  w_idle_below;
    logic                  w_arr_up_call;
    logic                  w_arr_up_more;
    logic                  w_arr_dn_call;
    logic                  w_arr_dn_more;
    logic                  w_req_here;
    logic                  w_move_last;
    logic                  w_door_last;

    assign w_tick        = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_pend_req    = r_pending | req;
    assign w_top         = (r_cur_floor == FLOOR_W'(NUM_FLOORS - 1));
    assign w_bottom      = (r_cur_floor == {FLOOR_W{1'b0}});
    assign w_up_floor    = r_cur_floor + FLOOR_W'(1);
    assign w_dn_floor    = r_cur_floor - FLOOR_W'(1);
    // IDLE decisions use only latched calls; arrival decisions also see this cycle's req.
    assign w_idle_here   = |(r_pending & f_onehot(r_cur_floor));
    assign w_idle_above  = |(r_pending & f_above(r_cur_floor));
    assign w_idle_below  = |(r_pending & f_below(r_cur_floor));
    assign w_arr_up_call = |(w_pend_req & f_onehot(w_up_floor));
    assign w_arr_up_more = |(w_pend_req & f_above(w_up_floor));
    assign w_arr_dn_call = |(w_pend_req & f_onehot(w_dn_floor));
    assign w_arr_dn_more = |(w_pend_req & f_below(w_dn_floor));
    assign w_req_here    = |(req & f_onehot(r_cur_floor));
    assign w_move_last   = (r_move_cnt == MOVE_W'(MOVE_TICKS - 1));
    assign w_door_last   = (r_door_cnt == DOOR_W'(DOOR_TICKS - 1));

    // Outputs decoded from registered state only.
    assign cur_floor = r_cur_floor;
    assign pending   = r_pending;
    assign moving    = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign dir_up    = (r_state == ST_MOVE_UP);
    assign dir_down  = (r_state == ST_MOVE_DOWN);
    assign door_open = (r_state == ST_DOOR);
    assign tick      = w_tick;

    // Free-running prescaler producing the timing tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= {PRESC_W{1'b0}};
        end else if (w_tick) begin
            r_presc <= {PRESC_W{1'b0}};
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Next-state, floor and tick-counter logic of the SCAN FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_floor_nxt    = r_cur_floor;
        w_last_up_nxt  = r_last_up;
        w_move_cnt_nxt = r_move_cnt;
        w_door_cnt_nxt = r_door_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_idle_here) begin
                    w_state_nxt    = ST_DOOR;
                    w_door_cnt_nxt = {DOOR_W{1'b0}};
                end else if (w_idle_above && (r_last_up || !w_idle_below) && !w_top) begin
                    w_state_nxt    = ST_MOVE_UP;
                    w_move_cnt_nxt = {MOVE_W{1'b0}};
                    w_last_up_nxt  = 1'b1;
                end else if (w_idle_below && !w_bottom) begin
                    w_state_nxt    = ST_MOVE_DOWN;
                    w_move_cnt_nxt = {MOVE_W{1'b0}};
                    w_last_up_nxt  = 1'b0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_MOVE_UP: begin
                if (w_top) begin
                    // Cannot travel past the top floor; fall back to IDLE.
                    w_state_nxt    = ST_IDLE;
                    w_move_cnt_nxt = {MOVE_W{1'b0}};
                end else if (w_tick) begin
                    if (w_move_last) begin
                        w_floor_nxt    = w_up_floor;
                        w_move_cnt_nxt = {MOVE_W{1'b0}};
                        if (w_arr_up_call) begin
                            w_state_nxt    = ST_DOOR;
                            w_door_cnt_nxt = {DOOR_W{1'b0}};
                        end else if (w_arr_up_more) begin
                            w_state_nxt    = ST_MOVE_UP;
                        end else begin
                            w_state_nxt    = ST_IDLE;
                        end
                    end else begin
                        w_move_cnt_nxt = r_move_cnt + MOVE_W'(1);
                    end
                end else begin
                    w_state_nxt    = ST_MOVE_UP;
                end
            end
            ST_MOVE_DOWN: begin
                if (w_bottom) begin
                    // Cannot travel below floor 0; fall back to IDLE.
                    w_state_nxt    = ST_IDLE;
                    w_move_cnt_nxt = {MOVE_W{1'b0}};
                end else if (w_tick) begin
                    if (w_move_last) begin
                        w_floor_nxt    = w_dn_floor;
                        w_move_cnt_nxt = {MOVE_W{1'b0}};
                        if (w_arr_dn_call) begin
                            w_state_nxt    = ST_DOOR;
                            w_door_cnt_nxt = {DOOR_W{1'b0}};
                        end else if (w_arr_dn_more) begin
                            w_state_nxt    = ST_MOVE_DOWN;
                        end else begin
                            w_state_nxt    = ST_IDLE;
                        end
                    end else begin
                        w_move_cnt_nxt = r_move_cnt + MOVE_W'(1);
                    end
                end else begin
                    w_state_nxt    = ST_MOVE_DOWN;
                end
            end
            ST_DOOR: begin
                if (w_req_here) begin
                    // A new call at this floor keeps the door open longer.
                    w_state_nxt    = ST_DOOR;
                    w_door_cnt_nxt = {DOOR_W{1'b0}};
                end else if (w_tick) begin
                    if (w_door_last) begin
                        w_state_nxt    = ST_IDLE;
                        w_door_cnt_nxt = {DOOR_W{1'b0}};
                    end else begin
                        w_door_cnt_nxt = r_door_cnt + DOOR_W'(1);
                    end
                end else begin
                    w_state_nxt    = ST_DOOR;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_move_cnt_nxt = {MOVE_W{1'b0}};
                w_door_cnt_nxt = {DOOR_W{1'b0}};
            end
        endcase
    end

    // Clear mask: the floor the car will be at, whenever the door is (still) open next cycle.
    always_comb begin
        if (w_state_nxt == ST_DOOR) begin
            w_clr = f_onehot(w_floor_nxt);
        end else begin
            w_clr = {NUM_FLOORS{1'b0}};
        end
    end

    // FSM state, car position, direction memory and tick counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cur_floor <= {FLOOR_W{1'b0}};
            r_last_up   <= 1'b1;
            r_move_cnt  <= {MOVE_W{1'b0}};
            r_door_cnt  <= {DOOR_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cur_floor <= w_floor_nxt;
            r_last_up   <= w_last_up_nxt;
            r_move_cnt  <= w_move_cnt_nxt;
            r_door_cnt  <= w_door_cnt_nxt;
        end
    end

    // Call latch: new calls set, the served floor clears, clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= {NUM_FLOORS{1'b0}};
        end else begin
            r_pending <= w_pend_req & ~w_clr;
        end
    end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for elevator_scan_controller with NUM_FLOORS=4, TICK_DIV=4,
// MOVE_TICKS=2, DOOR_TICKS=2. Cycle n counts rising edges since reset release;
// timing ticks are consumed on edges where n is a multiple of 4.
module tb_elevator_scan_controller;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [1:0] cur_floor;
    logic [3:0] pending;
    logic       moving;
    logic       dir_up;
    logic       dir_down;
    logic       door_open;
    logic       tick;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int saw_down = 0;

    elevator_scan_controller #(
        .NUM_FLOORS(4),
        .FLOOR_W   (2),
        .TICK_DIV  (4),
        .MOVE_TICKS(2),
        .DOOR_TICKS(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .cur_floor(cur_floor),
        .pending  (pending),
        .moving   (moving),
        .dir_up   (dir_up),
        .dir_down (dir_down),
        .door_open(door_open),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (dir_down === 1'b1) saw_down = 1;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        n = 0;
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        #2;
        // Reset state
        chk("rst_floor",   32'(cur_floor), 32'd0);
        chk("rst_pending", 32'(pending),   32'd0);
        chk("rst_moving",  32'(moving),    32'd0);
        chk("rst_door",    32'(door_open), 32'd0);
        chk("rst_tick",    32'(tick),      32'd0);
        req = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_ignored", 32'(pending), 32'd0);
        req = 4'b0000;
        release_reset();

        // Prescaler: tick during cycles 4, 8, 12 only
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("tick_c%0d", c), 32'(tick), 32'((c % 4) == 0));
            step();
        end

        // Current-floor call at floor 0 and door extension
        req = 4'b0001;
        step();
        req = 4'b0000;
        chk("cf_pend_set",   32'(pending),   32'b0001);
        chk("cf_not_door",   32'(door_open), 32'd0);
        step();
        chk("cf_door",       32'(door_open), 32'd1);
        chk("cf_pend_clr",   32'(pending),   32'b0000);
        run_to(17);
        req = 4'b0001;
        step();
        req = 4'b0000;
        chk("cf_absorb_pend", 32'(pending),  32'b0000);
        chk("cf_absorb_door", 32'(door_open), 32'd1);
        run_to(20);
        chk("cf_extended",   32'(door_open), 32'd1);
        run_to(23);
        chk("cf_still_open", 32'(door_open), 32'd1);
        run_to(24);
        chk("cf_closed",     32'(door_open), 32'd0);

        // Single call to floor 2
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk("sc_pending",    32'(pending), 32'b0100);
        chk("sc_idle",       32'(moving),  32'd0);
        step();
        chk("sc_dir_up",     32'(dir_up),  32'd1);
        run_to(31);
        chk("sc_floor0",     32'(cur_floor), 32'd0);
        run_to(32);
        chk("sc_floor1",     32'(cur_floor), 32'd1);
        chk("sc_still_up",   32'(dir_up),    32'd1);
        run_to(39);
        chk("sc_floor1b",    32'(cur_floor), 32'd1);
        run_to(40);
        chk("sc_floor2",     32'(cur_floor), 32'd2);
        chk("sc_door",       32'(door_open), 32'd1);
        chk("sc_pend_clr",   32'(pending),   32'b0000);
        run_to(47);
        chk("sc_door_open",  32'(door_open), 32'd1);
        run_to(48);
        chk("sc_door_shut",  32'(door_open), 32'd0);
        chk("sc_idle_end",   32'(moving),    32'd0);

        // Async reset while parked at floor 2
        reset = 1'b0;
        #2;
        chk("ar_floor", 32'(cur_floor), 32'd0);
        release_reset();

        // Reset mid-move from floor 0 to 1
        req = 4'b0010;
        step();
        req = 4'b0000;
        run_to(6);
        chk("rm_moving",  32'(moving),  32'd1);
        chk("rm_pending", 32'(pending), 32'b0010);
        reset = 1'b0;
        #2;
        chk("rm_floor",   32'(cur_floor), 32'd0);
        chk("rm_moving0", 32'(moving),    32'd0);
        chk("rm_dirup0",  32'(dir_up),    32'd0);
        chk("rm_pend0",   32'(pending),   32'd0);
        chk("rm_tick0",   32'(tick),      32'd0);
        release_reset();

        // SCAN order: up to 3 first, then down to 0
        req = 4'b1000;
        run_to(8);
        req = 4'b0000;
        chk("scan_floor1",  32'(cur_floor), 32'd1);
        chk("scan_up1",     32'(dir_up),    32'd1);
        req = 4'b0001;
        step();
        req = 4'b0000;
        chk("scan_pend",    32'(pending),   32'b1001);
        saw_down = 0;
        run_to(16);
        chk("scan_floor2",  32'(cur_floor), 32'd2);
        chk("scan_up2",     32'(dir_up),    32'd1);
        run_to(24);
        chk("scan_floor3",  32'(cur_floor), 32'd3);
        chk("scan_door3",   32'(door_open), 32'd1);
        chk("scan_pend3",   32'(pending),   32'b0001);
        run_to(32);
        chk("scan_closed3", 32'(door_open), 32'd0);
        chk("scan_no_down", 32'(saw_down),  32'd0);
        run_to(33);
        chk("scan_down",    32'(dir_down),  32'd1);
        run_to(40);
        chk("scan_floor2d", 32'(cur_floor), 32'd2);
        run_to(56);
        chk("scan_floor0",  32'(cur_floor), 32'd0);
        chk("scan_door0",   32'(door_open), 32'd1);
        chk("scan_pend0",   32'(pending),   32'b0000);
        run_to(64);
        chk("scan_idle",    32'(door_open), 32'd0);

        // Call for floor 1 in the exact arrival cycle
        req = 4'b1000;
        step();
        req = 4'b0000;
        run_to(71);
        chk("sim_pre_floor", 32'(cur_floor), 32'd0);
        req = 4'b0010;
        step();
        req = 4'b0000;
        chk("sim_floor1",  32'(cur_floor), 32'd1);
        chk("sim_door1",   32'(door_open), 32'd1);
        chk("sim_pend",    32'(pending),   32'b1000);
        run_to(81);
        chk("sim_resume",  32'(dir_up),    32'd1);
        run_to(96);
        chk("sim_floor3",  32'(cur_floor), 32'd3);
        chk("sim_door3",   32'(door_open), 32'd1);
        chk("sim_pend_end", 32'(pending),  32'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
